// File: rtl/mips_pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS PC sequencer: address width,
//               reset vector, FSM state encoding and next-PC select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          PC_WIDTH = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // Sequencer FSM state encoding
    localparam int          STATE_W  = 2;
    localparam logic [1:0]  ST_BOOT  = 2'd0;
    localparam logic [1:0]  ST_RUN   = 2'd1;
    localparam logic [1:0]  ST_HOLD  = 2'd2;

    // Next-PC source select, in increasing priority order
    localparam int          NEXT_PC_W      = 2;
    localparam logic [1:0]  NEXT_PC_SEQ    = 2'd0;
    localparam logic [1:0]  NEXT_PC_BRANCH = 2'd1;
    localparam logic [1:0]  NEXT_PC_JUMP   = 2'd2;
    localparam logic [1:0]  NEXT_PC_JR     = 2'd3;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_pc_sequencer_if
// Description : Request/response bundle between the decode stage (master) and
//               the PC sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_pc_sequencer_if #(
    parameter int PC_WIDTH = 32
);
    // Requests from decode/execute
    logic                stall;
    logic                is_branch;
    logic [PC_WIDTH-1:0] branch_offset;
    logic                jump;
    logic [25:0]         jump_index;
    logic                jr;
    logic [PC_WIDTH-1:0] jr_target;

    // Fetch address and status from the sequencer
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                instr_valid;
    logic                redirect;
    logic                addr_err;

    modport master (
        output stall, is_branch, branch_offset, jump, jump_index, jr, jr_target,
        input  pc, pc_plus4, instr_valid, redirect, addr_err
    );

    modport slave (
        input  stall, is_branch, branch_offset, jump, jump_index, jr, jr_target,
        output pc, pc_plus4, instr_valid, redirect, addr_err
    );

endinterface
`default_nettype wire

// File: rtl/mips_pc_sequencer_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : mips_target_calc
// Description : Combinational redirect-target computation with the
//               jr > jump > branch priority mux. Reports whether any
//               redirect is requested and whether the chosen JR target
//               was misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_target_calc
    import mips_pkg::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  wire logic [PC_WIDTH-1:0] i_pc_plus4,
    input  wire logic                i_is_branch,
    input  wire logic [PC_WIDTH-1:0] i_branch_offset,
    input  wire logic                i_jump,
    input  wire logic [25:0]         i_jump_index,
    input  wire logic                i_jr,
    input  wire logic [PC_WIDTH-1:0] i_jr_target,
    output logic      [PC_WIDTH-1:0] o_target,
    output logic                     o_req_valid,
    output logic                     o_misaligned
);

    logic [PC_WIDTH-1:0]  w_branch_tgt;
    logic [PC_WIDTH-1:0]  w_jump_tgt;
    logic [PC_WIDTH-1:0]  w_jr_tgt;
    logic [NEXT_PC_W-1:0] w_sel;

    // Candidate targets; the branch sum wraps modulo 2^PC_WIDTH naturally
    assign w_branch_tgt = i_pc_plus4 + (i_branch_offset << 2);
    assign w_jump_tgt   = {i_pc_plus4[PC_WIDTH-1:PC_WIDTH-4], i_jump_index, 2'b00};
    assign w_jr_tgt     = word_align(i_jr_target);

    // Priority select: jr beats jump beats a taken branch
    always_comb begin
        w_sel = NEXT_PC_SEQ;
        if (i_jr) begin
            w_sel = NEXT_PC_JR;
        end else if (i_jump) begin
            w_sel = NEXT_PC_JUMP;
        end else if (i_is_branch) begin
            w_sel = NEXT_PC_BRANCH;
        end
    end

    // Target mux and status for the selected source
    always_comb begin
        o_target     = i_pc_plus4;
        o_req_valid  = (w_sel != NEXT_PC_SEQ);
        o_misaligned = 1'b0;
        case (w_sel)
            NEXT_PC_JR: begin
                o_target     = w_jr_tgt;
                o_misaligned = |i_jr_target[1:0];
            end
            NEXT_PC_JUMP:   o_target = w_jump_tgt;
            NEXT_PC_BRANCH: o_target = w_branch_tgt;
            default:        o_target = i_pc_plus4;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mips_pc_sequencer
// Description : Owns the architectural PC. Chooses between sequential fetch
//               and redirect targets, and parks a redirect that arrives
//               during a stall in a one-entry pending buffer so it is applied
//               once the stall releases.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_pc_sequencer
    import mips_pkg::*;
#(
    parameter int                   PC_WIDTH = mips_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = mips_pkg::RESET_PC
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mips_pc_sequencer_if.slave      bus
);

    localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(4);

    logic [STATE_W-1:0]  r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_pc_plus4;
    logic                r_instr_valid;
    logic                r_redirect;
    logic                r_addr_err;
    logic [PC_WIDTH-1:0] r_pend_target;
    logic                r_pend_err;

    logic [PC_WIDTH-1:0] w_target;
    logic                w_req_valid;
    logic                w_misaligned;

    // Redirect target selection from the current fetch address
    mips_target_calc #(
        .PC_WIDTH (PC_WIDTH)
    ) u_target_calc (
        .i_pc_plus4      (r_pc_plus4),
        .i_is_branch     (bus.is_branch),
        .i_branch_offset (bus.branch_offset),
        .i_jump          (bus.jump),
        .i_jump_index    (bus.jump_index),
        .i_jr            (bus.jr),
        .i_jr_target     (bus.jr_target),
        .o_target        (w_target),
        .o_req_valid     (w_req_valid),
        .o_misaligned    (w_misaligned)
    );

    // Sequencer FSM, PC register and pending-redirect buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_pc_plus4    <= RESET_PC + C_PC_STEP;
            r_instr_valid <= 1'b0;
            r_redirect    <= 1'b0;
            r_addr_err    <= 1'b0;
            r_pend_target <= '0;
            r_pend_err    <= 1'b0;
        end else begin
            // Flags are single-cycle pulses unless re-asserted below
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    // Requests are dropped here; PC stays at the reset vector
                    r_state       <= ST_RUN;
                    r_instr_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (w_req_valid) begin
                            r_pc       <= w_target;
                            r_pc_plus4 <= w_target + C_PC_STEP;
                            r_redirect <= 1'b1;
                            r_addr_err <= w_misaligned;
                        end else begin
                            r_pc       <= r_pc_plus4;
                            r_pc_plus4 <= r_pc_plus4 + C_PC_STEP;
                        end
                    end else if (w_req_valid) begin
                        // Error is reported when the target is applied, not now
                        r_pend_target <= w_target;
                        r_pend_err    <= w_misaligned;
                        r_state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // First captured redirect wins; later requests are ignored
                    if (!bus.stall) begin
                        r_pc       <= r_pend_target;
                        r_pc_plus4 <= r_pend_target + C_PC_STEP;
                        r_redirect <= 1'b1;
                        r_addr_err <= r_pend_err;
                        r_pend_err <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                default: begin
                    r_state       <= ST_BOOT;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = r_pc_plus4;
    assign bus.instr_valid = r_instr_valid;
    assign bus.redirect    = r_redirect;
    assign bus.addr_err    = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_mips_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_pc_sequencer
// Description : Self-checking bench for mips_pc_sequencer. Directed scenarios
//               followed by random traffic, all compared against a
//               cycle-level behavioural model of the PC rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mips_pc_sequencer_if #(.PC_WIDTH(32)) bus ();

    mips_pc_sequencer #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: PC value, whether we are still in the boot cycle,
    // and a queue holding at most one deferred redirect.
    logic [31:0] m_pc;
    bit          m_booting;
    bit          m_valid;
    bit          m_redirect;
    bit          m_err;
    logic [31:0] m_pend_q[$];
    bit          m_pend_err_q[$];

    // Single comparison point for every check in the bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge with the given inputs
    task automatic model_step(input bit r, input bit s, input bit b, input logic [31:0] off,
                              input bit j, input logic [25:0] idx, input bit jr,
                              input logic [31:0] jrt);
        logic [31:0] seq;
        logic [31:0] tgt;
        bit          req;
        bit          e;
        seq = m_pc + 32'd4;
        req = jr || j || b;
        e   = 1'b0;
        tgt = seq;
        if (jr) begin
            tgt = jrt & 32'hFFFF_FFFC;
            e   = (jrt % 4) != 0;
        end else if (j) begin
            tgt = {seq[31:28], idx, 2'b00};
        end else if (b) begin
            tgt = seq + off * 32'd4;
        end
        m_redirect = 1'b0;
        m_err      = 1'b0;
        if (r) begin
            m_pc      = 32'h0;
            m_booting = 1'b1;
            m_valid   = 1'b0;
            m_pend_q.delete();
            m_pend_err_q.delete();
        end else if (m_booting) begin
            m_booting = 1'b0;
            m_valid   = 1'b1;
        end else if (m_pend_q.size() != 0) begin
            if (!s) begin
                m_pc       = m_pend_q.pop_front();
                m_err      = m_pend_err_q.pop_front();
                m_redirect = 1'b1;
            end
        end else if (req) begin
            if (s) begin
                m_pend_q.push_back(tgt);
                m_pend_err_q.push_back(e);
            end else begin
                m_pc       = tgt;
                m_err      = e;
                m_redirect = 1'b1;
            end
        end else if (!s) begin
            m_pc = seq;
        end
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge
    task automatic cycle(input bit r, input bit s, input bit b, input logic [31:0] off,
                         input bit j, input logic [25:0] idx, input bit jr,
                         input logic [31:0] jrt);
        rst               = r;
        bus.stall         = s;
        bus.is_branch     = b;
        bus.branch_offset = off;
        bus.jump          = j;
        bus.jump_index    = idx;
        bus.jr            = jr;
        bus.jr_target     = jrt;
        model_step(r, s, b, off, j, idx, jr, jrt);
        @(posedge clk);
        @(negedge clk);
        check("pc",          bus.pc,          m_pc);
        check("pc_plus4",    bus.pc_plus4,    m_pc + 32'd4);
        check("instr_valid", bus.instr_valid, m_valid);
        check("redirect",    bus.redirect,    m_redirect);
        check("addr_err",    bus.addr_err,    m_err);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
    endtask

    initial begin
        bit          r, s, b, j, jr;
        logic [31:0] off, jrt;
        logic [15:0] imm;
        logic [25:0] idx;

        bus.stall = 1'b0; bus.is_branch = 1'b0; bus.branch_offset = '0;
        bus.jump = 1'b0; bus.jump_index = '0; bus.jr = 1'b0; bus.jr_target = '0;
        m_pc = 32'h0; m_booting = 1'b1; m_valid = 1'b0;
        m_redirect = 1'b0; m_err = 1'b0;
        @(negedge clk);

        // Reset and sequential start-up
        cycle(1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
        check("reset_pc", bus.pc, 32'h0);
        check("reset_valid", bus.instr_valid, 1'b0);
        idle(); check("boot_exit_pc", bus.pc, 32'h0); check("run_valid", bus.instr_valid, 1'b1);
        idle(); check("seq_pc_4", bus.pc, 32'h4);
        idle(); check("seq_pc_8", bus.pc, 32'h8);
        idle(); check("seq_pc_c", bus.pc, 32'hC);

        // Backward branch from 0x100, then plain sequential from 0x100
        cycle(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h100);
        check("jr_to_100", bus.pc, 32'h100);
        cycle(0, 0, 1, 32'hFFFF_FFFE, 0, 26'h0, 0, 32'h0);
        check("branch_back", bus.pc, 32'hFC);
        check("branch_redirect", bus.redirect, 1'b1);
        idle(); check("redirect_clears", bus.redirect, 1'b0);
        idle(); check("no_branch_seq", bus.pc, 32'h104);

        // All three requests together: misaligned JR wins
        cycle(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'h1000_0000);
        cycle(0, 0, 1, 32'h10, 1, 26'h3FF_FFFF, 1, 32'h403);
        check("prio_jr_pc", bus.pc, 32'h400);
        check("prio_addr_err", bus.addr_err, 1'b1);

        // Branch captured during stall; later jump ignored; applied on release
        cycle(0, 1, 1, 32'h4, 0, 26'h0, 0, 32'h0);
        check("stall_hold_1", bus.pc, 32'h400);
        cycle(0, 1, 0, 32'h0, 1, 26'h123, 0, 32'h0);
        check("stall_hold_2", bus.pc, 32'h400);
        idle();
        check("pending_applied", bus.pc, 32'h414);
        check("pending_redirect", bus.redirect, 1'b1);
        idle(); check("pending_pulse_once", bus.redirect, 1'b0);

        // Wrap-around at the top of the address space
        cycle(0, 0, 0, 32'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", bus.pc_plus4, 32'h0);
        idle(); check("wrap_to_0", bus.pc, 32'h0);
        idle(); check("wrap_to_4", bus.pc, 32'h4);

        // Reset while holding discards the pending target
        cycle(0, 1, 1, 32'h40, 0, 26'h0, 0, 32'h0);
        cycle(1, 1, 0, 32'h0, 0, 26'h0, 0, 32'h0);
        check("hold_reset_pc", bus.pc, 32'h0);
        idle(); check("hold_reset_boot_pc", bus.pc, 32'h0);
        idle(); check("hold_reset_no_pending", bus.pc, 32'h4);

        // A request in the boot cycle is dropped
        cycle(1, 0, 0, 32'h0, 0, 26'h0, 0, 32'h0);
        cycle(0, 1, 0, 32'h0, 0, 26'h0, 1, 32'h800);
        idle(); check("boot_req_dropped", bus.pc, 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 30);
            b   = ($urandom_range(0, 99) < 25);
            j   = ($urandom_range(0, 99) < 10);
            jr  = ($urandom_range(0, 99) < 10);
            imm = 16'($urandom);
            off = {{16{imm[15]}}, imm};
            idx = 26'($urandom);
            jrt = $urandom;
            if ($urandom_range(0, 1) == 0) jrt[1:0] = 2'b00;
            cycle(r, s, b, off, j, idx, jr, jrt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
